push_conditioner: RTL and testbench
===================================

// Module: push_conditioner
// PURPOSE
//  Source side of the push-button interface consumed by the up/down counter.
//  Synchronises and debounces N raw active-low buttons and drives clean active-low levels.
//  Each accepted press gives exactly one high->low edge on o_Push, plus one-cycle pulses
//  on o_Press and o_Release.
//  Sits between board pins and any edge-detecting consumer (counter, menu FSM).
// PARAMETERS
//  N_BTN       2         number of independent button channels
//  DB_CYC      500000    debounce window in clocks (10 ms @ 50 MHz); must be >= 2
//  REPEAT_DLY  25000000  hold time before first auto-repeat (0.5 s); PUSH_AUTOREPEAT_EN only
//  REPEAT_PER  5000000   auto-repeat period (0.1 s); PUSH_AUTOREPEAT_EN only
// PORTS
//  i_Clk      in   1      system clock, 50 MHz, single clock domain
//  i_Rst      in   1      asynchronous, active-high reset
//  i_Push     in   N_BTN  raw button pins, active-low (0 = pressed), asynchronous to i_Clk
//  o_Push     out  N_BTN  debounced level, active-low, registered
//  o_Press    out  N_BTN  1-cycle pulse per accepted press (and per repeat)
//  o_Release  out  N_BTN  1-cycle pulse per accepted release
// BEHAVIOUR
//  - Reset (async, i_Rst=1):
//    - sync flops = 1; o_Push = all 1s; o_Press = 0; o_Release = 0.
//    - every channel in IDLE; all counters = 0.
//    - Release of reset mid-bounce restarts debouncing from IDLE; no spurious pulses.
//  - Synchroniser: 2 flops per bit. s = second-stage output.
//  - Per-channel FSM (channels fully independent):
//    - IDLE: s==0 -> PRESS_WAIT, cnt=0.
//    - PRESS_WAIT: s==1 -> IDLE (glitch rejected, no output). Else cnt++.
//      At cnt==DB_CYC-1 -> HELD; same edge: o_Push[k]<=0, o_Press[k]<=1 for one cycle.
//    - HELD: s==1 -> RELEASE_WAIT, cnt=0.
//    - RELEASE_WAIT: s==0 -> HELD (bounce, no output). Else cnt++.
//      At cnt==DB_CYC-1 -> IDLE; o_Push[k]<=1, o_Release[k]<=1 for one cycle.
//  - Latency: raw edge to o_Push change = 2 (sync) + DB_CYC clocks when input stays stable.
//  - Width: cnt is $clog2(DB_CYC) bits. Counters saturate by construction; never wrap.
//  - A bounce shorter than DB_CYC anywhere resets that window only; o_Push never toggles twice per press.
//  - Simultaneous presses on several channels are each reported in their own bit, same cycle allowed.
//  - o_Press and o_Release never both high for one channel in the same cycle.
// CONFIGURATION
//  PUSH_AUTOREPEAT_EN defined:
//    - HELD runs rpt counter ($clog2(REPEAT_DLY) bits), cleared on entry to HELD.
//    - At REPEAT_DLY-1 cycles held, and then every REPEAT_PER cycles:
//      o_Press[k] pulses 1 cycle and o_Push[k] goes 1 for exactly that cycle, then returns 0.
//      This gives edge-detecting consumers a fresh falling edge.
//    - Leaving HELD stops repeats immediately. A repeat is never emitted in RELEASE_WAIT.
//  Not defined:
//    - Exactly one o_Press per accepted press; o_Push stays 0 while HELD.
//    - rpt logic absent from netlist.
// STRUCTURE
//  - Shared package push_pkg:
//    - state encoding localparams ST_IDLE=2'd0, ST_PRESS_WAIT=2'd1, ST_HELD=2'd2, ST_RELEASE_WAIT=2'd3.
//    - default timing constants for 50 MHz.
//  - Sub-module push_debounce: one channel (sync + FSM + counters).
//    - push_conditioner instantiates N_BTN copies in a generate loop.
// TESTING (bench overrides DB_CYC=4, REPEAT_DLY=20, REPEAT_PER=6)
//  1 Reset held with i_Push=2'b00 -> o_Push=2'b11, no pulses; release reset -> press accepted 6 clks later.
//  2 i_Push[0] 1->0 stable -> o_Push[0]=0 and o_Press[0]=1 exactly 6 clks later, for 1 clk.
//  3 i_Push[0] low for 2 clks then high -> o_Push, o_Press, o_Release unchanged (glitch rejected).
//  4 Held press, release bouncing 1/0/1 at 2-clk spacing, then stable 1 -> one o_Release only.
//     It comes 6 clks after the final stable edge.
//  5 Both buttons pressed same cycle -> o_Press=2'b11 in one cycle; o_Push=2'b00.
//  6 PUSH_AUTOREPEAT_EN, hold 40 clks after accept -> repeats at +19, +25, +31, +37.
//     Each repeat: o_Push[k]=1 for 1 clk. Without the macro: zero repeats.

Source files
------------

// File: rtl/push_pkg.sv
// Shared state encoding and 50 MHz timing defaults for the push-button conditioner.
// Optional feature macro used by the design files: PUSH_AUTOREPEAT_EN.
package push_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } btn_state_e;

  localparam int DEF_DB_CYC     = 500000;    // 10 ms
  localparam int DEF_REPEAT_DLY = 25000000;  // 0.5 s
  localparam int DEF_REPEAT_PER = 5000000;   // 0.1 s

endpackage

// File: rtl/push_debounce.sv
// One button channel: 2-flop synchroniser, debounce FSM, registered active-low level and pulses.
// Macro PUSH_AUTOREPEAT_EN adds held-button auto-repeat; without it no repeat logic exists.
module push_debounce
  import push_pkg::*;
#(
  parameter int DB_CYC     = DEF_DB_CYC
`ifdef PUSH_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DLY = DEF_REPEAT_DLY,
  parameter int REPEAT_PER = DEF_REPEAT_PER
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press,
  output logic rel
);

  localparam int CW = $clog2(DB_CYC);

  logic [1:0]    sync;
  logic          s;
  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          accept;
  logic          rpt_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], btn};
  end
  assign s = sync[1];

  assign cnt_inc = cnt_q + 1'b1;

  // The IDLE/HELD cycle that spots the edge counts as the first of the DB_CYC stable samples.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!s) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (s) begin
          state_d = ST_IDLE;
        end else if (cnt_inc == CW'(DB_CYC - 1)) begin
          state_d = ST_HELD;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_HELD: begin
        if (s) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (!s) begin
          state_d = ST_HELD;
        end else if (cnt_inc == CW'(DB_CYC - 1)) begin
          state_d = ST_IDLE;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PUSH_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_DLY);

  logic [RW-1:0] rpt_q, rpt_d, rpt_inc;

  assign rpt_inc = rpt_q + 1'b1;

  // Held outside HELD at zero, so entry always starts a fresh delay; after a
  // repeat the counter is rewound so the next one lands REPEAT_PER later.
  always_comb begin
    rpt_d    = '0;
    rpt_fire = 1'b0;
    if (state_q == ST_HELD && !s) begin
      if (rpt_inc == RW'(REPEAT_DLY - 1)) begin
        rpt_fire = 1'b1;
        rpt_d    = RW'(REPEAT_DLY - 1 - REPEAT_PER);
      end else begin
        rpt_d = rpt_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rpt_q <= '0;
    else     rpt_q <= rpt_d;
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 1'b1;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      level <= !(state_d == ST_HELD || state_d == ST_RELEASE_WAIT) || rpt_fire;
      press <= (state_q == ST_PRESS_WAIT && accept) || rpt_fire;
      rel   <= (state_q == ST_RELEASE_WAIT && accept);
    end
  end

endmodule

// File: rtl/push_conditioner.sv
// N independent debounced active-low buttons feeding edge-detecting consumers.
// Macro PUSH_AUTOREPEAT_EN enables auto-repeat on held buttons (REPEAT_* parameters exist only then).
module push_conditioner
  import push_pkg::*;
#(
  parameter int N_BTN      = 2,
  parameter int DB_CYC     = DEF_DB_CYC
`ifdef PUSH_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DLY = DEF_REPEAT_DLY,
  parameter int REPEAT_PER = DEF_REPEAT_PER
`endif
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic [N_BTN-1:0] i_Push,
  output logic [N_BTN-1:0] o_Push,
  output logic [N_BTN-1:0] o_Press,
  output logic [N_BTN-1:0] o_Release
);

  for (genvar k = 0; k < N_BTN; k++) begin : g_btn
    push_debounce #(
      .DB_CYC    (DB_CYC)
`ifdef PUSH_AUTOREPEAT_EN
      ,
      .REPEAT_DLY(REPEAT_DLY),
      .REPEAT_PER(REPEAT_PER)
`endif
    ) u_db (
      .clk  (i_Clk),
      .rst  (i_Rst),
      .btn  (i_Push[k]),
      .level(o_Push[k]),
      .press(o_Press[k]),
      .rel  (o_Release[k])
    );
  end

endmodule

// File: tb/tb_push_conditioner.sv
// Directed bench for push_conditioner with DB_CYC=4 (REPEAT_DLY=20, REPEAT_PER=6 when auto-repeat is built).
// Pulses are matched against a queue of expected events stamped with the cycle they must appear in.
module tb_push_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] pin = 2'b00;
  logic [1:0] o_push, o_press, o_rel;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int         cyc;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] push;
  } ev_t;

  ev_t exp_q[$];

  push_conditioner #(
    .N_BTN     (2),
    .DB_CYC    (4)
`ifdef PUSH_AUTOREPEAT_EN
    ,
    .REPEAT_DLY(20),
    .REPEAT_PER(6)
`endif
  ) dut (
    .i_Clk    (clk),
    .i_Rst    (rst),
    .i_Push   (pin),
    .o_Push   (o_push),
    .o_Press  (o_press),
    .o_Release(o_rel)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected event due 'dly' clocks after the current cycle.
  task automatic expect_ev(input int dly, input logic [1:0] pr, input logic [1:0] rl, input logic [1:0] pu);
    ev_t e;
    e.cyc   = cyc + dly;
    e.press = pr;
    e.rel   = rl;
    e.push  = pu;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    ev_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      check("missed_event", cyc, e.cyc);
    end
    if ((o_press | o_rel) != 2'b00) begin
      check("press_rel_exclusive", o_press & o_rel, 0);
      if (exp_q.size() == 0) begin
        check("spurious_pulse", {o_press, o_rel}, 0);
      end else begin
        e = exp_q.pop_front();
        check("ev_cycle", cyc, e.cyc);
        check("ev_press", o_press, e.press);
        check("ev_release", o_rel, e.rel);
        check("ev_level", o_push, e.push);
      end
    end
  end

  initial begin
    // Reset held with both buttons pressed
    rst = 1'b1;
    pin = 2'b00;
    step(3);
    check("rst_level", o_push, 2'b11);
    check("rst_press", o_press, 2'b00);
    check("rst_release", o_rel, 2'b00);

    rst = 1'b0;
    expect_ev(6, 2'b11, 2'b00, 2'b00);
    step(8);
    check("post_rst_level", o_push, 2'b00);
    pin = 2'b11;
    expect_ev(6, 2'b00, 2'b11, 2'b11);
    step(8);
    check("post_rst_released", o_push, 2'b11);

    // Single stable press on channel 0, held 40 clocks after acceptance
    pin = 2'b10;
    expect_ev(6, 2'b01, 2'b00, 2'b10);
`ifdef PUSH_AUTOREPEAT_EN
    expect_ev(6 + 19, 2'b01, 2'b00, 2'b11);
    expect_ev(6 + 25, 2'b01, 2'b00, 2'b11);
    expect_ev(6 + 31, 2'b01, 2'b00, 2'b11);
    expect_ev(6 + 37, 2'b01, 2'b00, 2'b11);
`endif
    step(5);
    check("press_not_early", o_push, 2'b11);
    step(1);
    check("press_level", o_push, 2'b10);
    step(20);
    check("held_level_after_first_repeat", o_push, 2'b10);
    step(20);

    // Bouncing release: 1/0/1 at 2-clock spacing, then stable
    pin = 2'b11;
    step(2);
    pin = 2'b10;
    step(2);
    pin = 2'b11;
    expect_ev(6, 2'b00, 2'b01, 2'b11);
    step(5);
    check("release_not_early", o_push, 2'b10);
    step(3);
    check("release_level", o_push, 2'b11);

    // Two-clock glitch must be rejected
    pin = 2'b10;
    step(2);
    pin = 2'b11;
    step(10);
    check("glitch_level", o_push, 2'b11);

    // Simultaneous press on both channels
    pin = 2'b00;
    expect_ev(6, 2'b11, 2'b00, 2'b00);
    step(6);
    check("both_level", o_push, 2'b00);
    step(2);
    pin = 2'b11;
    expect_ev(6, 2'b00, 2'b11, 2'b11);
    step(8);
    check("both_released", o_push, 2'b11);

    // Reset asserted mid-debounce, released while the button is still bouncing
    pin = 2'b01;
    step(3);
    rst = 1'b1;
    #1;
    check("midrst_level", o_push, 2'b11);
    check("midrst_press", o_press, 2'b00);
    step(2);
    rst = 1'b0;
    step(2);
    pin = 2'b11;
    step(10);
    check("midrst_after_level", o_push, 2'b11);

    step(10);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
